// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and status controller for the asynchronous FIFO.
// Keeps binary/Gray read pointers, registered fill level, almost-empty and underflow flags.
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  R_inc,
    input  logic                  CLR_ERR,
    input  logic [ADDR_WIDTH:0]   Rq2_Wptr,
    output logic                  R_en,
    output logic [ADDR_WIDTH-1:0] R_addr,
    output logic [ADDR_WIDTH:0]   R_ptr,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   R_level,
    output logic                  UNDERFLOW,
    output logic                  UNDERFLOW_STICKY
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] wbin;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic          uf_q, uf_d;
    logic          ufs_q, ufs_d;

    assign R_en = R_inc & ~empty_q;

    // Gray decode: each binary bit is the XOR of its Gray bit and all higher ones.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(Rq2_Wptr >> i);
        end
    end

    always_comb begin
        rbin_d  = rbin_q + PW'(R_en);
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        level_d = wbin - rbin_d;
        empty_d = (rgray_d == Rq2_Wptr);
        ae_d    = (level_d <= PW'(AE_THRESH));
        uf_d    = R_inc & empty_q;
        // A new underflow in the same cycle as the clear keeps the flag set.
        ufs_d   = uf_d | (ufs_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
            uf_q    <= 1'b0;
            ufs_q   <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            level_q <= level_d;
            empty_q <= empty_d;
            ae_q    <= ae_d;
            uf_q    <= uf_d;
            ufs_q   <= ufs_d;
        end
    end

    assign R_addr           = rbin_q[ADDR_WIDTH-1:0];
    assign R_ptr            = rgray_q;
    assign EMPTY            = empty_q;
    assign ALMOST_EMPTY     = ae_q;
    assign R_level          = level_q;
    assign UNDERFLOW        = uf_q;
    assign UNDERFLOW_STICKY = ufs_q;

endmodule
